bsg_gateway_fixed_latency_channel: RTL and testbench

- Cycle-accurate, in-order, fixed-latency channel model for the gateway testbench.
- Sits between a nonsynth endpoint and the chip DUT, e.g. host MMIO io_resp to DUT io_resp_i, or burst mem resp header/data to DUT.
- Replaces continuous-assign transport delays with a registered latency measured in clock cycles, so IO timing is modelled at the cycle level and back-pressure is honoured.
- Buffers up to els_p in-flight messages, each released no earlier than latency_p cycles after acceptance.

---
 rtl/bsg_gateway_fixed_latency_channel.sv | 110 +++++++++++
 tb/tb_bsg_gateway_fixed_latency_channel.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_gateway_fixed_latency_channel.sv
// bsg_gateway_fixed_latency_channel
// In-order, fixed-latency valid/ready channel. Each accepted message is held
// in a small circular buffer together with a countdown; it becomes visible at
// the head once its countdown reaches zero, i.e. latency_p cycles after it was
// accepted. Back-pressure from the consumer is honoured and the buffer holds
// up to els_p messages in flight.
module bsg_gateway_fixed_latency_channel #(
  parameter int unsigned width_p   = 64,
  parameter int unsigned latency_p = 2,
  parameter int unsigned els_p     = 4,
  parameter int unsigned lg_els_lp = $clog2(els_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,

  input  logic [width_p-1:0]   data_i,
  input  logic                 v_i,
  output logic                 ready_and_o,

  output logic [width_p-1:0]   data_o,
  output logic                 v_o,
  input  logic                 ready_and_i,

  output logic [lg_els_lp-1:0] count_o
);

  localparam int unsigned cd_w_lp  = (latency_p > 1) ? $clog2(latency_p) : 1;
  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  localparam logic [cd_w_lp-1:0]   cd_init_lp  = cd_w_lp'(latency_p - 1);
  localparam logic [ptr_w_lp-1:0]  ptr_last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [lg_els_lp-1:0] count_full_lp = lg_els_lp'(els_p);

  logic [width_p-1:0]   mem_q [els_p];
  logic [cd_w_lp-1:0]   cd_q  [els_p];
  logic [cd_w_lp-1:0]   cd_d  [els_p];

  logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d;
  logic [lg_els_lp-1:0] count_q, count_d;

  logic enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_incr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Handshake outputs; gated by reset so they read 0 while reset is held.
  always_comb begin
    ready_and_o = reset_n_i & (count_q != count_full_lp);
    v_o         = reset_n_i & (count_q != '0) & (cd_q[rd_ptr_q] == '0);
    data_o      = mem_q[rd_ptr_q];
    count_o     = count_q;
    enq         = v_i & ready_and_o;
    deq         = v_o & ready_and_i;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_ptr_d = deq ? ptr_incr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = enq ? ptr_incr(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + lg_els_lp'(1);
      2'b01:   count_d = count_q - lg_els_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Countdown aging: every nonzero countdown steps toward zero. Free slots may
  // also age, which is harmless because a write always reloads the slot.
  always_comb begin
    for (int unsigned i = 0; i < els_p; i++) begin
      cd_d[i] = cd_q[i];
      if (cd_q[i] != '0) cd_d[i] = cd_q[i] - cd_w_lp'(1);
      if (enq && (wr_ptr_q == ptr_w_lp'(i))) cd_d[i] = cd_init_lp;
    end
  end

  // Control state: pointers, occupancy and countdowns, asynchronously cleared.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < els_p; i++) cd_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int unsigned i = 0; i < els_p; i++) cd_q[i] <= cd_d[i];
    end
  end

  // Message storage; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

`ifndef SYNTHESIS
  // Producer must hold a pending message stable until it is accepted.
  a_v_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_i && !ready_and_o) |=> v_i);
  a_data_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_i && !ready_and_o) |=> $stable(data_i));
  a_params: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (latency_p >= 1) && (els_p >= 1));
`endif

endmodule

// File: tb/tb_bsg_gateway_fixed_latency_channel.sv
// Testbench for bsg_gateway_fixed_latency_channel. Three instances with
// different latency/depth; a scoreboard queue per instance is filled by the
// stimulus and drained by a negedge monitor.
module tb_bsg_gateway_fixed_latency_channel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int compared = 0;
  int mismatched = 0;

  // A: latency 2, depth 4
  logic [15:0] a_data_i, a_data_o;
  logic a_v_i, a_ready_o, a_v_o, a_ready_i;
  logic [2:0] a_count_o;
  // B: latency 3, depth 4
  logic [15:0] b_data_i, b_data_o;
  logic b_v_i, b_ready_o, b_v_o, b_ready_i;
  logic [2:0] b_count_o;
  // C: latency 1, depth 3
  logic [15:0] c_data_i, c_data_o;
  logic c_v_i, c_ready_o, c_v_o, c_ready_i;
  logic [1:0] c_count_o;

  bsg_gateway_fixed_latency_channel #(.width_p(16), .latency_p(2), .els_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(a_data_i), .v_i(a_v_i),
    .ready_and_o(a_ready_o), .data_o(a_data_o), .v_o(a_v_o),
    .ready_and_i(a_ready_i), .count_o(a_count_o));

  bsg_gateway_fixed_latency_channel #(.width_p(16), .latency_p(3), .els_p(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(b_data_i), .v_i(b_v_i),
    .ready_and_o(b_ready_o), .data_o(b_data_o), .v_o(b_v_o),
    .ready_and_i(b_ready_i), .count_o(b_count_o));

  bsg_gateway_fixed_latency_channel #(.width_p(16), .latency_p(1), .els_p(3)) dut_c (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(c_data_i), .v_i(c_v_i),
    .ready_and_o(c_ready_o), .data_o(c_data_o), .v_o(c_v_o),
    .ready_and_i(c_ready_i), .count_o(c_count_o));

  typedef struct {
    logic [15:0] d;
    int unsigned t;      // edge number at which the message was accepted
    bit          exact;  // consumer always ready: output must appear exactly at t+latency-1
  } ent_t;

  ent_t qa[$], qb[$], qc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int id);
    case (id)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic q_push(input int id, input ent_t e);
    case (id)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int id, output ent_t e);
    case (id)
      0: e = qa.pop_front();
      1: e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
  endtask

  task automatic q_front(input int id, output ent_t e);
    case (id)
      0: e = qa[0];
      1: e = qb[0];
      default: e = qc[0];
    endcase
  endtask

  // One monitor step for one instance, evaluated on the falling edge.
  task automatic mon_step(input int id, input string nm, input logic v, input logic [15:0] d,
                          input logic rdy, input int cnt, input int unsigned lat, input int els);
    ent_t e;
    chk({nm, "_count_le_els"}, 32'(cnt <= els), 32'd1);
    if (v) begin
      if (q_size(id) == 0) begin
        chk({nm, "_unexpected_output"}, 32'(d), 32'hDEAD_0000);
      end else begin
        q_front(id, e);
        chk({nm, "_data"}, 32'(d), 32'(e.d));
        if (e.exact) chk({nm, "_latency"}, cyc, e.t + lat - 1);
        else         chk({nm, "_min_latency"}, 32'(cyc >= e.t + lat - 1), 32'd1);
        if (rdy) q_pop(id, e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, "A", a_v_o, a_data_o, a_ready_i, int'(a_count_o), 2, 4);
    mon_step(1, "B", b_v_o, b_data_o, b_ready_i, int'(b_count_o), 3, 4);
    mon_step(2, "C", c_v_o, c_data_o, c_ready_i, int'(c_count_o), 1, 3);
  end

  function automatic logic rdy_o(input int id);
    case (id)
      0: return a_ready_o;
      1: return b_ready_o;
      default: return c_ready_o;
    endcase
  endfunction

  task automatic drive(input int id, input logic v, input logic [15:0] d);
    case (id)
      0: begin a_v_i = v; a_data_i = d; end
      1: begin b_v_i = v; b_data_i = d; end
      default: begin c_v_i = v; c_data_i = d; end
    endcase
  endtask

  // Offer one message, hold it until accepted, then record it in the scoreboard.
  task automatic send(input int id, input logic [15:0] d, input bit exact, output int waits);
    ent_t e;
    bit ok;
    ok = 1'b0;
    waits = 0;
    drive(id, 1'b1, d);
    while (!ok && waits <= 60) begin
      @(negedge clk);
      if (rdy_o(id)) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      chk("send_timeout", 32'(waits), 32'd0);
    end else begin
      e.d = d; e.t = cyc + 1; e.exact = exact;
      q_push(id, e);
    end
    @(posedge clk); #1;
    drive(id, 1'b0, d);
  endtask

  task automatic drain(input int id, input string nm);
    for (int i = 0; i < 60 && q_size(id) != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk({nm, "_drained"}, 32'(q_size(id)), 32'd0);
  endtask

  int w;
  bit wrap_done;

  initial begin
    a_v_i = 0; b_v_i = 0; c_v_i = 0;
    a_data_i = '0; b_data_i = '0; c_data_i = '0;
    a_ready_i = 1; b_ready_i = 1; c_ready_i = 1;

    // Reset state
    #2;
    chk("rst_a_ready", 32'(a_ready_o), 0);
    chk("rst_a_v", 32'(a_v_o), 0);
    chk("rst_a_count", 32'(a_count_o), 0);
    chk("rst_b_ready", 32'(b_ready_o), 0);
    chk("rst_c_count", 32'(c_count_o), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_a_ready", 32'(a_ready_o), 1);

    // Single-message latency on B (latency 3)
    send(1, 16'h00A5, 1'b1, w);
    chk("b_lat_e0_v", 32'(b_v_o), 0);
    @(posedge clk); #1;
    chk("b_lat_e1_v", 32'(b_v_o), 0);
    @(posedge clk); #1;
    chk("b_lat_e2_v", 32'(b_v_o), 1);
    chk("b_lat_e2_data", 32'(b_data_o), 32'h00A5);
    @(posedge clk); #1;
    chk("b_lat_e3_v", 32'(b_v_o), 0);
    chk("b_lat_e3_count", 32'(b_count_o), 0);

    // Streaming on A (latency 2, depth 4)
    for (int i = 1; i <= 8; i++) begin
      send(0, 16'(i), 1'b1, w);
      chk("a_stream_ready", 32'(w), 0);
    end
    drain(0, "a_stream");

    // Full back-pressure on A
    a_ready_i = 0;
    for (int i = 1; i <= 4; i++) send(0, 16'h0100 + 16'(i), 1'b0, w);
    a_v_i = 1; a_data_i = 16'h0105;
    @(negedge clk);
    chk("a_full_ready", 32'(a_ready_o), 0);
    chk("a_full_count", 32'(a_count_o), 4);
    @(posedge clk); #1;
    a_ready_i = 1;
    @(negedge clk);
    chk("a_full_no_bypass", 32'(a_ready_o), 0);
    @(posedge clk); #1;
    a_ready_i = 0;
    chk("a_full_ready_after_deq", 32'(a_ready_o), 1);
    chk("a_full_count_after_deq", 32'(a_count_o), 3);
    begin
      ent_t e;
      @(negedge clk);
      chk("a_full_fifth_accept", 32'(a_ready_o), 1);
      e.d = 16'h0105; e.t = cyc + 1; e.exact = 1'b0;
      if (a_ready_o) qa.push_back(e);
    end
    @(posedge clk); #1;
    a_v_i = 0;
    chk("a_full_count_refill", 32'(a_count_o), 4);
    a_ready_i = 1;
    drain(0, "a_full");
    chk("a_full_count_end", 32'(a_count_o), 0);

    // Reset mid-operation on A
    a_ready_i = 0;
    for (int i = 1; i <= 3; i++) send(0, 16'h0200 + 16'(i), 1'b0, w);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_a_v", 32'(a_v_o), 0);
    chk("midrst_a_ready", 32'(a_ready_o), 0);
    chk("midrst_a_count", 32'(a_count_o), 0);
    qa.delete(); qb.delete(); qc.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_ready", 32'(a_ready_o), 1);
    a_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", 32'(a_v_o), 0);
    end

    // Stalled head on C (latency 1)
    c_ready_i = 0;
    send(2, 16'h0033, 1'b0, w);
    send(2, 16'h0044, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("c_stall_v", 32'(c_v_o), 1);
      chk("c_stall_data", 32'(c_data_o), 32'h0033);
    end
    @(posedge clk); #1;
    c_ready_i = 1;
    @(posedge clk); #1;
    c_ready_i = 0;
    chk("c_second_v", 32'(c_v_o), 1);
    chk("c_second_data", 32'(c_data_o), 32'h0044);
    c_ready_i = 1;
    drain(2, "c_stall");

    // Wrap and odd depth on C with random consumer readiness
    wrap_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(2, 16'h0300 + 16'(i), 1'b0, w);
        wrap_done = 1'b1;
      end
      begin
        while (!wrap_done) begin
          @(posedge clk); #1;
          c_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    c_ready_i = 1;
    drain(2, "c_wrap");
    chk("c_wrap_count_end", 32'(c_count_o), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
